// File: rtl/alu2_wide_sequencer_if.sv
// Host and ALU-side signal bundle for alu2_wide_sequencer.
// slave = the sequencer; master = the host/ALU environment driving it.
interface alu2_wide_sequencer_if #(
   parameter int LANES = 4
);
   localparam int W = 8 * LANES;

   // Both host channels use valid/ready: a transfer happens on a rising edge
   // where valid and ready are both high; valid, once raised, holds its payload
   // stable until that edge and never waits on ready to rise first.
   logic         rx_valid;
   logic         rx_ready;
   logic [2:0]   rx_opcode;
   logic         rx_carryflag;
   logic [W-1:0] rx_operand0;
   logic [W-1:0] rx_operand1;

   logic         tx_valid;
   logic         tx_ready;
   logic [W-1:0] tx_result;
   logic         tx_carryflag;
   logic         tx_zeroflag;
   logic         tx_signflag;
   logic         tx_error;

   logic         alu_enable;
   logic         alu_write;
   logic         alu_strobe;
   logic         alu_carryflag;
   logic [2:0]   alu_opcode;
   logic [7:0]   alu_operand0;
   logic [7:0]   alu_operand1;
   logic [7:0]   alu_result;
   logic         alu_carryflag_in;
   logic         alu_zeroflag_in;
   logic         alu_signflag_in;
   logic         alu_ready;

   modport slave (
      input  rx_valid, rx_opcode, rx_carryflag, rx_operand0, rx_operand1, tx_ready,
      input  alu_result, alu_carryflag_in, alu_zeroflag_in, alu_signflag_in, alu_ready,
      output rx_ready, tx_valid, tx_result, tx_carryflag, tx_zeroflag, tx_signflag, tx_error,
      output alu_enable, alu_write, alu_strobe, alu_carryflag, alu_opcode, alu_operand0, alu_operand1
   );

   modport master (
      output rx_valid, rx_opcode, rx_carryflag, rx_operand0, rx_operand1, tx_ready,
      output alu_result, alu_carryflag_in, alu_zeroflag_in, alu_signflag_in, alu_ready,
      input  rx_ready, tx_valid, tx_result, tx_carryflag, tx_zeroflag, tx_signflag, tx_error,
      input  alu_enable, alu_write, alu_strobe, alu_carryflag, alu_opcode, alu_operand0, alu_operand1
   );
endinterface

// File: rtl/alu2_wide_sequencer.sv
// Issues one wide operation to the 8-bit ALU lane by lane (LSB first), chaining carry.
// Optional ALU response watchdog: define ALU2_WIDE_SEQ_WATCHDOG_EN.
module alu2_wide_sequencer #(
   parameter int LANES   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                  aclk,
   input  logic                  areset,
   alu2_wide_sequencer_if.slave  bus,
   output logic [1:0]            dbg_state
);
   localparam int W = 8 * LANES;

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

   state_t       state, next_state;
   logic [2:0]   lane;
   logic [2:0]   op_q;
   logic [W-1:0] a_q, b_q, res_q;
   logic         carry_q, zero_q, sign_q, cout_q, err_q;
   logic         accept, last_lane, timeout, lane_done;
   logic [5:0]   byte_idx;

   assign byte_idx  = {lane, 3'b000};
   assign last_lane = (lane == 3'(LANES - 1));
   assign accept    = bus.rx_valid & bus.rx_ready;
   assign lane_done = (state == WAIT) & bus.alu_ready;

`ifdef ALU2_WIDE_SEQ_WATCHDOG_EN
   logic [7:0] wd;
   assign timeout = (state == WAIT) & ~bus.alu_ready & (wd == 8'(TIMEOUT - 1));

   always_ff @(posedge aclk) begin
      if (areset || state == ISSUE) wd <= 8'd0;
      else if (state == WAIT && !bus.alu_ready) wd <= wd + 8'd1;
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge aclk) begin
      if (areset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:  if (accept) next_state = ISSUE;
         ISSUE: next_state = WAIT;
         WAIT: begin
            if (bus.alu_ready) next_state = last_lane ? DONE : ISSUE;
            else if (timeout)  next_state = DONE;
         end
         DONE:  if (bus.tx_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         lane    <= 3'd0;
         op_q    <= 3'd0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
         sign_q  <= 1'b0;
         cout_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         if (state == IDLE && accept) begin
            op_q    <= bus.rx_opcode;
            a_q     <= bus.rx_operand0;
            b_q     <= bus.rx_operand1;
            carry_q <= bus.rx_carryflag;
            lane    <= 3'd0;
            zero_q  <= 1'b1;
         end
         if (lane_done) begin
            res_q[byte_idx +: 8] <= bus.alu_result;
            carry_q <= bus.alu_carryflag_in;
            zero_q  <= zero_q & bus.alu_zeroflag_in;
            if (last_lane) begin
               sign_q <= bus.alu_signflag_in;
               cout_q <= bus.alu_carryflag_in;
            end else begin
               lane <= lane + 3'd1;
            end
         end else if (timeout) begin
            // Aborted operation reports an all-zero result with only the error flag set.
            res_q  <= '0;
            zero_q <= 1'b0;
            sign_q <= 1'b0;
            cout_q <= 1'b0;
            err_q  <= 1'b1;
         end
         if (state == DONE && bus.tx_ready) begin
            err_q <= 1'b0;
            lane  <= 3'd0;
         end
      end
   end

   // Ready is held low while reset is asserted even though the state is already IDLE.
   assign bus.rx_ready      = (state == IDLE) & ~areset;
   assign bus.tx_valid      = (state == DONE);
   assign bus.tx_result     = res_q;
   assign bus.tx_carryflag  = cout_q;
   assign bus.tx_zeroflag   = zero_q & (state == DONE);
   assign bus.tx_signflag   = sign_q;
   assign bus.tx_error      = err_q;

   assign bus.alu_enable    = (state == ISSUE) | (state == WAIT);
   assign bus.alu_write     = (state == ISSUE);
   assign bus.alu_strobe    = (state == ISSUE);
   assign bus.alu_carryflag = bus.alu_enable & carry_q;
   assign bus.alu_opcode    = bus.alu_enable ? op_q : 3'd0;
   assign bus.alu_operand0  = bus.alu_enable ? a_q[byte_idx +: 8] : 8'd0;
   assign bus.alu_operand1  = bus.alu_enable ? b_q[byte_idx +: 8] : 8'd0;

   assign dbg_state = state;
endmodule

// File: tb/tb_alu2_wide_sequencer.sv
// Directed bench for alu2_wide_sequencer (LANES=4) with a behavioural 8-bit ALU.
// Watchdog expectations follow ALU2_WIDE_SEQ_WATCHDOG_EN.
module tb_alu2_wide_sequencer;
   localparam int LANES   = 4;
   localparam int TIMEOUT = 255;

   logic       aclk = 1'b0;
   logic       areset;
   logic [1:0] dbg_state;
   int         total = 0;
   int         bad = 0;

   alu2_wide_sequencer_if #(.LANES(LANES)) bus ();

   alu2_wide_sequencer #(.LANES(LANES), .TIMEOUT(TIMEOUT)) dut (
      .aclk      (aclk),
      .areset    (areset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 aclk = ~aclk;

   // Behavioural ALU: op 0 = add with carry, other ops = xor with carry passed through.
   int         ready_delay = 0;
   bit         ready_en = 1'b1;
   int         alu_cnt = 0;
   int         strobe_cnt = 0;
   int         double_strobe = 0;
   bit         prev_strobe = 1'b0;
   logic       cin_log [8];
   logic [2:0] op_log [8];
   logic [8:0] sum;

   always @(negedge aclk) begin
      if (areset) begin
         alu_cnt = 0;
         bus.alu_ready = 1'b0;
      end else if (bus.alu_strobe) begin
         if (prev_strobe) double_strobe++;
         if (strobe_cnt < 8) begin
            cin_log[strobe_cnt] = bus.alu_carryflag;
            op_log[strobe_cnt]  = bus.alu_opcode;
         end
         strobe_cnt++;
         alu_cnt = 0;
         bus.alu_ready = 1'b0;
      end else if (bus.alu_enable) begin
         alu_cnt++;
         bus.alu_ready = ready_en && (alu_cnt > ready_delay);
      end else begin
         bus.alu_ready = 1'b0;
      end
      prev_strobe = bus.alu_strobe;
      if (bus.alu_opcode == 3'd0)
         sum = {1'b0, bus.alu_operand0} + {1'b0, bus.alu_operand1} + {8'd0, bus.alu_carryflag};
      else
         sum = {bus.alu_carryflag, bus.alu_operand0 ^ bus.alu_operand1};
      bus.alu_result       = sum[7:0];
      bus.alu_carryflag_in = sum[8];
      bus.alu_zeroflag_in  = (sum[7:0] == 8'd0);
      bus.alu_signflag_in  = sum[7];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [31:0] r_res;
   logic        r_c, r_z, r_s, r_e, r_got, r_stable, r_rx_seen;
   int          r_edges;

   // One wide operation: accept, wait for tx_valid (bounded), hold, then consume.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input int delay, input int hold, input int limit);
      @(negedge aclk);
      ready_delay = delay;
      strobe_cnt = 0;
      check("rx_ready_idle", bus.rx_ready, 1'b1);
      bus.rx_valid = 1'b1;
      bus.rx_opcode = op;
      bus.rx_operand0 = a;
      bus.rx_operand1 = b;
      bus.rx_carryflag = cin;
      @(posedge aclk);
      @(negedge aclk);
      bus.rx_valid = 1'b0;
      r_rx_seen = bus.rx_ready;
      r_edges = 0;
      do begin
         @(posedge aclk);
         r_edges++;
         @(negedge aclk);
         if (bus.rx_ready) r_rx_seen = 1'b1;
      end while (!bus.tx_valid && r_edges < limit);
      r_got = bus.tx_valid;
      r_res = bus.tx_result;
      r_c = bus.tx_carryflag;
      r_z = bus.tx_zeroflag;
      r_s = bus.tx_signflag;
      r_e = bus.tx_error;
      r_stable = 1'b1;
      if (r_got) begin
         repeat (hold) begin
            @(negedge aclk);
            if (bus.tx_valid !== 1'b1 || bus.tx_result !== r_res || bus.tx_carryflag !== r_c ||
                bus.tx_zeroflag !== r_z || bus.tx_signflag !== r_s || bus.rx_ready !== 1'b0)
               r_stable = 1'b0;
         end
         bus.tx_ready = 1'b1;
         @(posedge aclk);
         @(negedge aclk);
         bus.tx_ready = 1'b0;
         check("tx_valid_after_consume", bus.tx_valid, 1'b0);
         check("rx_ready_after_consume", bus.rx_ready, 1'b1);
      end
   endtask

   int s_before;

   initial begin
      areset = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_opcode = 3'd0;
      bus.rx_carryflag = 1'b0;
      bus.rx_operand0 = '0;
      bus.rx_operand1 = '0;
      bus.tx_ready = 1'b0;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check("reset_rx_ready", bus.rx_ready, 1'b0);
      check("reset_tx_valid", bus.tx_valid, 1'b0);
      check("reset_tx_result", bus.tx_result, 32'h0);
      check("reset_tx_flags", {bus.tx_carryflag, bus.tx_zeroflag, bus.tx_signflag, bus.tx_error}, 4'h0);
      check("reset_alu_ctl", {bus.alu_enable, bus.alu_write, bus.alu_strobe, bus.alu_carryflag}, 4'h0);
      check("reset_alu_data", {bus.alu_opcode, bus.alu_operand0, bus.alu_operand1}, 19'h0);
      check("reset_state", dbg_state, 2'd0);
      areset = 1'b0;
      @(posedge aclk);

      // 0xFF + 0x01: carry ripples out of lane 0 only.
      run_op(3'd0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 0, 0, 100);
      check("t1_latency", r_edges, 8);
      check("t1_result", r_res, 32'h0000_0100);
      check("t1_flags_czse", {r_c, r_z, r_s, r_e}, 4'b0000);
      check("t1_strobes", strobe_cnt, 4);

      run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 0, 100);
      check("t2_result", r_res, 32'h0);
      check("t2_flags_czse", {r_c, r_z, r_s, r_e}, 4'b1100);
      check("t2_lane_carry_in", {cin_log[0], cin_log[1], cin_log[2], cin_log[3]}, 4'b0111);

      run_op(3'd0, 32'h7FFF_FFFF, 32'h0, 1'b1, 0, 0, 100);
      check("t3_result", r_res, 32'h8000_0000);
      check("t3_flags_czse", {r_c, r_z, r_s, r_e}, 4'b0010);
      check("t3_lane0_carry_in", cin_log[0], 1'b1);

      // Slow ALU (ready after 5 extra WAIT cycles per lane) and host holding off 3 cycles.
      run_op(3'd0, 32'h1234_5678, 32'h1111_1111, 1'b0, 5, 3, 200);
      check("t4_latency", r_edges, 28);
      check("t4_result", r_res, 32'h2345_6789);
      check("t4_flags_czse", {r_c, r_z, r_s, r_e}, 4'b0000);
      check("t4_hold_stable", r_stable, 1'b1);
      check("t4_strobes", strobe_cnt, 4);
      check("t4_rx_ready_low", r_rx_seen, 1'b0);

      // Non-add opcode reaches every lane unchanged; carry-in passes through the model.
      run_op(3'd3, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b1, 0, 0, 100);
      check("t5_result", r_res, 32'h0F0F_F0F0);
      check("t5_flags_czse", {r_c, r_z, r_s, r_e}, 4'b1000);
      check("t5_opcode_lane3", op_log[3], 3'd3);

      // Reset while lane 2 is waiting on the ALU.
      @(negedge aclk);
      ready_delay = 5;
      strobe_cnt = 0;
      bus.rx_valid = 1'b1;
      bus.rx_opcode = 3'd0;
      bus.rx_operand0 = 32'h0101_0101;
      bus.rx_operand1 = 32'h0101_0101;
      bus.rx_carryflag = 1'b0;
      @(posedge aclk);
      @(negedge aclk);
      bus.rx_valid = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (strobe_cnt == 3 && !bus.alu_strobe) break;
         @(negedge aclk);
      end
      check("t6_reached_lane2_wait", dbg_state, 2'd2);
      areset = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      check("t6_rst_tx_valid", bus.tx_valid, 1'b0);
      check("t6_rst_rx_ready", bus.rx_ready, 1'b0);
      check("t6_rst_alu_ctl", {bus.alu_enable, bus.alu_write, bus.alu_strobe, bus.alu_carryflag}, 4'h0);
      check("t6_rst_alu_data", {bus.alu_opcode, bus.alu_operand0, bus.alu_operand1}, 19'h0);
      check("t6_rst_tx_result", bus.tx_result, 32'h0);
      check("t6_rst_state", dbg_state, 2'd0);
      areset = 1'b0;
      s_before = strobe_cnt;
      @(posedge aclk);
      @(negedge aclk);
      check("t6_rx_ready_release", bus.rx_ready, 1'b1);
      repeat (5) @(negedge aclk);
      check("t6_no_strobe", strobe_cnt, s_before);
      run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 0, 0, 100);
      check("t6_after_result", r_res, 32'h0);
      check("t6_after_flags_czse", {r_c, r_z, r_s, r_e}, 4'b1100);

      // ALU never answers.
      ready_en = 1'b0;
`ifdef ALU2_WIDE_SEQ_WATCHDOG_EN
      run_op(3'd0, 32'h1234_5678, 32'h1111_1111, 1'b0, 0, 2, 600);
      check("t7_wd_valid", r_got, 1'b1);
      check("t7_wd_latency", r_edges, TIMEOUT + 1);
      check("t7_wd_result", r_res, 32'h0);
      check("t7_wd_flags_czse", {r_c, r_z, r_s, r_e}, 4'b0001);
      check("t7_wd_error_cleared", bus.tx_error, 1'b0);
`else
      run_op(3'd0, 32'h1234_5678, 32'h1111_1111, 1'b0, 0, 0, 600);
      check("t7_no_wd_valid", r_got, 1'b0);
      check("t7_no_wd_error", bus.tx_error, 1'b0);
      areset = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      areset = 1'b0;
`endif
      ready_en = 1'b1;
      check("no_double_strobe", double_strobe, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
